// File: rtl/complete_arbiter_pkg.sv
// Shared types for the complete-stage arbiter.
// Holds the complete-bus payload and arbiter sizing constants.
package complete_arbiter_pkg;

  localparam int ARB_STARVE_LIMIT = 8;
  localparam int ARB_RR_W         = 4;
  localparam int ARB_WAIT_W       = 4;
  localparam int ROB_W            = 5;
  localparam int DATA_W           = 32;

  typedef struct packed {
    logic              ready;
    logic [ROB_W-1:0]  ROBNumber;
    logic [DATA_W-1:0] Result;
  } complete_stage_struct;

endpackage

// File: rtl/complete_arbiter_rr_pick2.sv
// Rotated two-hot priority picker.
// A starved requester claims slot 0, then round-robin order fills the rest.
module rr_pick2
  import complete_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]        req_i,
  input  logic [N-1:0]        starve_i,
  input  logic [ARB_RR_W-1:0] ptr_i,
  output logic                v0_o,
  output logic                v1_o,
  output logic [ARB_RR_W-1:0] idx0_o,
  output logic [ARB_RR_W-1:0] idx1_o
);

  logic                v0, v1;
  logic [ARB_RR_W-1:0] idx0, idx1;

  always_comb begin
    int j;
    j    = 0;
    v0   = 1'b0;
    v1   = 1'b0;
    idx0 = '0;
    idx1 = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (starve_i[i]) begin
        v0   = 1'b1;
        idx0 = ARB_RR_W'(i);
      end
    end
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (req_i[j] && !(v0 && idx0 == ARB_RR_W'(j))) begin
        if (!v0) begin
          v0   = 1'b1;
          idx0 = ARB_RR_W'(j);
        end else if (!v1) begin
          v1   = 1'b1;
          idx1 = ARB_RR_W'(j);
        end
      end
    end
  end

  assign v0_o   = v0;
  assign v1_o   = v1;
  assign idx0_o = idx0;
  assign idx1_o = idx1;

endmodule

// File: rtl/complete_arbiter.sv
// Complete-stage arbiter: up to two FU results per cycle onto the CDB.
// Round-robin with starvation override; all state lives here.
module complete_arbiter
  import complete_arbiter_pkg::*;
#(
  parameter int NUM_FU       = 3,
  parameter int NUM_CDB      = 2,
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  complete_stage_struct i_fu_req [0:NUM_FU-1],
  output logic [0:NUM_FU-1]    o_fu_ack,
  input  logic                 i_stall,
  input  logic                 i_flush,
  output complete_stage_struct o_cdb [0:NUM_CDB-1],
  output logic                 o_dup_err
);

  localparam logic [ARB_WAIT_W-1:0] WAIT_MAX = '1;

  logic [ARB_RR_W-1:0]   rr_q, rr_d;
  logic [ARB_WAIT_W-1:0] wait_q [NUM_FU];
  logic [ARB_WAIT_W-1:0] wait_d [NUM_FU];
  complete_stage_struct  cdb_q [NUM_CDB];
  complete_stage_struct  cdb_d [NUM_CDB];
  logic                  dup_q, dup_d;

  logic [NUM_FU-1:0]     req, starve, gnt;
  logic                  v0, v1, go;
  logic [ARB_RR_W-1:0]   idx0, idx1;
  complete_stage_struct  s0, s1;

  function automatic logic [ARB_RR_W-1:0] nxt(
    input logic [ARB_RR_W-1:0] x
  );
    return (int'(x) == NUM_FU - 1) ? '0 : x + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      req[i]    = i_fu_req[i].ready;
      starve[i] = req[i] &&
                  (int'(wait_q[i]) >= STARVE_LIMIT);
    end
  end

  rr_pick2 #(
    .N(NUM_FU)
  ) u_pick (
    .req_i   (req),
    .starve_i(starve),
    .ptr_i   (rr_q),
    .v0_o    (v0),
    .v1_o    (v1),
    .idx0_o  (idx0),
    .idx1_o  (idx1)
  );

  // Acks are held off during reset so nothing is consumed before release.
  assign go = i_rst_n && !i_stall && !i_flush;

  always_comb begin
    s0 = '0;
    s1 = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      gnt[i] = go &&
               ((v0 && idx0 == ARB_RR_W'(i)) ||
                (v1 && idx1 == ARB_RR_W'(i)));
      if (v0 && idx0 == ARB_RR_W'(i)) s0 = i_fu_req[i];
      if (v1 && idx1 == ARB_RR_W'(i)) s1 = i_fu_req[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      o_fu_ack[i] = gnt[i];
    end
  end

  always_comb begin
    rr_d  = rr_q;
    dup_d = dup_q;
    for (int i = 0; i < NUM_FU; i++) begin
      wait_d[i] = wait_q[i];
      if (i_flush || !req[i] || gnt[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != WAIT_MAX) begin
        wait_d[i] = wait_q[i] + 1'b1;
      end
    end
    for (int s = 0; s < NUM_CDB; s++) begin
      cdb_d[s] = cdb_q[s];
      if (i_flush) begin
        cdb_d[s] = '0;
      end else if (!i_stall) begin
        if (s == 0)      cdb_d[s] = s0;
        else if (s == 1) cdb_d[s] = s1;
        else             cdb_d[s] = '0;
      end
    end
    if (go) begin
      if (v1)      rr_d = nxt(idx1);
      else if (v0) rr_d = nxt(idx0);
      if (v0 && v1 && s0.ROBNumber == s1.ROBNumber) begin
        dup_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_q  <= '0;
      dup_q <= 1'b0;
      for (int i = 0; i < NUM_FU; i++) wait_q[i] <= '0;
      for (int s = 0; s < NUM_CDB; s++) cdb_q[s] <= '0;
    end else begin
      rr_q  <= rr_d;
      dup_q <= dup_d;
      for (int i = 0; i < NUM_FU; i++) wait_q[i] <= wait_d[i];
      for (int s = 0; s < NUM_CDB; s++) cdb_q[s] <= cdb_d[s];
    end
  end

  assign o_cdb     = cdb_q;
  assign o_dup_err = dup_q;

endmodule

// File: tb/tb_complete_arbiter.sv
// Self-checking bench for complete_arbiter.
// Directed scenarios plus random traffic against a queue-based model.
module tb_complete_arbiter;
  import complete_arbiter_pkg::*;

  localparam int NFU  = 3;
  localparam int NCDB = 2;
  localparam int LIM  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0;
  logic flush = 1'b0;
  complete_stage_struct req [0:NFU-1];
  logic [0:NFU-1]       ack;
  complete_stage_struct cdb [0:NCDB-1];
  logic                 dup;

  int checks   = 0;
  int failures = 0;

  int                   m_rr;
  int                   m_wait [NFU];
  complete_stage_struct m_cdb [NCDB];
  bit                   m_dup;
  logic [0:NFU-1]       e_ack;
  int                   picks [$];

  complete_arbiter #(
    .NUM_FU(NFU),
    .NUM_CDB(NCDB),
    .STARVE_LIMIT(LIM)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_fu_req (req),
    .o_fu_ack (ack),
    .i_stall  (stall),
    .i_flush  (flush),
    .o_cdb    (cdb),
    .o_dup_err(dup)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] obs,
                       logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr  = 0;
    m_dup = 1'b0;
    for (int i = 0; i < NFU; i++) m_wait[i] = 0;
    for (int s = 0; s < NCDB; s++) m_cdb[s] = '0;
  endtask

  // Priority list: one starved FU (lowest index) first, then rotation.
  task automatic model_comb();
    int  j;
    bit  found;
    picks = {};
    found = 1'b0;
    for (int i = 0; i < NFU; i++) begin
      if (!found && req[i].ready && m_wait[i] >= LIM) begin
        picks.push_back(i);
        found = 1'b1;
      end
    end
    for (int k = 0; k < NFU; k++) begin
      j = (m_rr + k) % NFU;
      if (req[j].ready && !(found && picks[0] == j) &&
          picks.size() < NCDB)
        picks.push_back(j);
    end
    e_ack = '0;
    if (rst_n && !stall && !flush)
      foreach (picks[p]) e_ack[picks[p]] = 1'b1;
  endtask

  task automatic model_clk();
    for (int i = 0; i < NFU; i++) begin
      if (flush || !req[i].ready || e_ack[i]) m_wait[i] = 0;
      else if (m_wait[i] < 15) m_wait[i]++;
    end
    if (flush) begin
      for (int s = 0; s < NCDB; s++) m_cdb[s] = '0;
    end else if (!stall) begin
      for (int s = 0; s < NCDB; s++) begin
        if (s < picks.size()) m_cdb[s] = req[picks[s]];
        else m_cdb[s] = '0;
      end
      if (picks.size() > 0)
        m_rr = (picks[picks.size()-1] + 1) % NFU;
      if (picks.size() == 2 &&
          req[picks[0]].ROBNumber == req[picks[1]].ROBNumber)
        m_dup = 1'b1;
    end
  endtask

  task automatic step(string tag);
    #1;
    model_comb();
    check({tag, ".ack"}, 64'(ack), 64'(e_ack));
    @(posedge clk);
    #1;
    model_clk();
    check({tag, ".cdb0"}, 64'(cdb[0]), 64'(m_cdb[0]));
    check({tag, ".cdb1"}, 64'(cdb[1]), 64'(m_cdb[1]));
    check({tag, ".dup"}, 64'(dup), 64'(m_dup));
    for (int i = 0; i < NFU; i++)
      if (e_ack[i]) req[i] = '0;
  endtask

  task automatic put(int i, int rob, int res);
    req[i].ready     = 1'b1;
    req[i].ROBNumber = ROB_W'(rob);
    req[i].Result    = DATA_W'(res);
  endtask

  initial begin
    for (int i = 0; i < NFU; i++) req[i] = '0;
    model_reset();
    put(0, 1, 100);
    put(1, 2, 200);
    put(2, 3, 300);
    repeat (2) @(posedge clk);
    #2;
    check("rst.ack", 64'(ack), 64'(0));
    check("rst.cdb0", 64'(cdb[0]), 64'(0));
    check("rst.cdb1", 64'(cdb[1]), 64'(0));
    check("rst.dup", 64'(dup), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    step("s028a");
    check("s028a.rob0", 64'(cdb[0].ROBNumber), 64'(1));
    check("s028a.rob1", 64'(cdb[1].ROBNumber), 64'(2));
    step("s028b");
    check("s028b.rob0", 64'(cdb[0].ROBNumber), 64'(3));
    step("idle");

    put(1, 5, 42);
    step("s029a");
    check("s029.res", 64'(cdb[0].Result), 64'(42));
    check("s029.rdy1", 64'(cdb[1].ready), 64'(0));
    step("s029b");

    stall = 1'b1;
    put(2, 9, 99);
    repeat (10) step("s030st");
    stall = 1'b0;
    step("s030a");
    check("s030.rob0", 64'(cdb[0].ROBNumber), 64'(9));
    step("s030b");

    put(0, 14, 140);
    step("pre");
    stall = 1'b1;
    put(0, 3, 30);
    put(1, 4, 40);
    put(2, 6, 60);
    repeat (9) step("starve_st");
    stall = 1'b0;
    step("starve_a");
    check("starve.rob0", 64'(cdb[0].ROBNumber), 64'(3));
    step("starve_b");
    step("starve_c");

    put(0, 1, 11);
    put(1, 12, 12);
    put(2, 23, 13);
    flush = 1'b1;
    stall = 1'b1;
    step("s032");
    check("s032.rdy0", 64'(cdb[0].ready), 64'(0));
    flush = 1'b0;
    stall = 1'b0;
    repeat (3) step("s032b");

    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(0, 9) < 2);
      flush = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < NFU; i++)
        if (!req[i].ready && $urandom_range(0, 1) == 1)
          put(i, i * 10 + int'($urandom_range(0, 9)),
              int'($urandom));
      step("rand");
    end
    stall = 1'b0;
    flush = 1'b0;
    repeat (4) step("drain");

    put(0, 7, 70);
    put(2, 7, 72);
    step("s031a");
    check("s031.set", 64'(dup), 64'(1));
    repeat (20) step("s031idle");
    check("s031.hold", 64'(dup), 64'(1));

    put(0, 11, 1);
    put(1, 12, 2);
    put(2, 13, 3);
    step("s033a");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("s033.cdb0", 64'(cdb[0]), 64'(0));
    check("s033.cdb1", 64'(cdb[1]), 64'(0));
    check("s033.ack", 64'(ack), 64'(0));
    check("s033.dup", 64'(dup), 64'(0));
    put(0, 11, 1);
    put(1, 12, 2);
    put(2, 13, 3);
    @(negedge clk);
    rst_n = 1'b1;
    step("s033b");
    check("s033b.rob0", 64'(cdb[0].ROBNumber), 64'(11));
    repeat (3) step("s033c");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
